// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the on-chip memory frame reader.
// State encoding, minimum Ethernet frame size and memory word geometry.
package frame_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int MIN_FRAME_BYTES = 60;
    localparam int BYTES_PER_WORD  = 4;

endpackage

// File: rtl/onchip_mem_frame_reader_if.sv
// Command, Avalon-MM read master and byte-stream source bundle of the frame reader.
// master = the reader itself, slave = the environment (memory, command source, MAC).
interface onchip_mem_frame_reader_if #(
    parameter int ADDR_W = 17,
    parameter int LEN_W  = 11
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;

    logic              src_valid;
    logic              src_ready;
    logic [7:0]        src_data;
    logic              src_sop;
    logic              src_eop;

    logic              busy;
    logic              done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, src_ready,
        output cmd_ready, avm_address, avm_read, avm_byteenable,
               src_valid, src_data, src_sop, src_eop, busy, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, src_ready,
        input  cmd_ready, avm_address, avm_read, avm_byteenable,
               src_valid, src_data, src_sop, src_eop, busy, done
    );
endinterface

// File: rtl/frame_reader_word_fifo.sv
// Word FIFO for returned read data; free count feeds the read-issue credit check.
// Push visible at the head the next cycle; caller guarantees no push when full and no pop when empty.
module frame_reader_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign free  = (PW+1)'(DEPTH) - count;

endmodule

// File: rtl/onchip_mem_frame_reader.sv
// Fetches a frame from 32-bit on-chip memory and streams it LSB-first as bytes; ONCHIP_MEM_FRAME_READER_PAD_EN pads short frames to 60 bytes.
// First read 1 cycle after the command, first byte READ_LATENCY+2 cycles after; reads are credit-limited by FIFO space, bytes held under src_ready low.
module onchip_mem_frame_reader
    import frame_reader_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int LEN_W        = 11,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    onchip_mem_frame_reader_if.master     bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        words_left;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        out_len_q;
    logic [LEN_W-1:0]        byte_idx;
    logic [READ_LATENCY-1:0] tag_pipe;
    logic [CW-1:0]           inflight;
    logic                    done_q;

    logic [CW-1:0]           fifo_free;
    logic                    fifo_empty;
    logic [31:0]             fifo_head;
    logic                    fifo_push;
    logic                    fifo_pop;

    logic [LEN_W:0]          len_plus3;
    logic [LEN_W-1:0]        words_init;
    logic [LEN_W-1:0]        out_len_init;
    logic                    read_req;
    logic                    rd_accept;
    logic                    pad_zone;
    logic                    out_vld;
    logic [1:0]              lane;
    logic                    byte_fire;
    logic                    last_byte;

    assign len_plus3  = {1'b0, bus.cmd_len} + (LEN_W+1)'(3);
    assign words_init = {1'b0, len_plus3[LEN_W:2]};

`ifdef ONCHIP_MEM_FRAME_READER_PAD_EN
    assign out_len_init = (bus.cmd_len < LEN_W'(MIN_FRAME_BYTES)) ? LEN_W'(MIN_FRAME_BYTES) : bus.cmd_len;
    // Past the real payload the bytes are synthesized zeros; the FIFO is not touched.
    assign pad_zone     = (byte_idx >= len_q);
`else
    assign out_len_init = bus.cmd_len;
    assign pad_zone     = 1'b0;
`endif

    // Credit: a read may issue only if its data is guaranteed a FIFO slot on return.
    assign read_req  = (state == FETCH) && (words_left != '0) && (fifo_free > inflight);
    assign rd_accept = read_req && !bus.avm_waitrequest;
    assign fifo_push = tag_pipe[READ_LATENCY-1];

    assign lane      = byte_idx[1:0];
    assign out_vld   = (state != IDLE) && (pad_zone || !fifo_empty);
    assign byte_fire = out_vld && bus.src_ready;
    assign last_byte = (byte_idx == out_len_q - LEN_W'(1));
    assign fifo_pop  = byte_fire && !pad_zone &&
                       ((lane == 2'(BYTES_PER_WORD-1)) || (byte_idx == len_q - LEN_W'(1)));

    frame_reader_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (bus.avm_readdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .free      (fifo_free)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            words_left <= '0;
            len_q      <= '0;
            out_len_q  <= '0;
            byte_idx   <= '0;
            tag_pipe   <= '0;
            inflight   <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            tag_pipe[0] <= rd_accept;
            for (int i = 1; i < READ_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];

            case ({rd_accept, fifo_push})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            addr_q     <= bus.cmd_addr;
                            words_left <= words_init;
                            len_q      <= bus.cmd_len;
                            out_len_q  <= out_len_init;
                            byte_idx   <= '0;
                            state      <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rd_accept) begin
                        addr_q     <= addr_q + 1'b1;
                        words_left <= words_left - 1'b1;
                        if (words_left == LEN_W'(1)) state <= DRAIN;
                    end
                end
                default: ;
            endcase

            if (byte_fire) begin
                byte_idx <= byte_idx + 1'b1;
                if (last_byte) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready      = (state == IDLE);
    assign bus.busy           = (state != IDLE);
    assign bus.done           = done_q;
    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = read_req;
    assign bus.avm_byteenable = 4'hF;
    assign bus.src_valid      = out_vld;
    assign bus.src_data       = (out_vld && !pad_zone) ? fifo_head[{lane, 3'b000} +: 8] : 8'h00;
    assign bus.src_sop        = out_vld && (byte_idx == '0);
    assign bus.src_eop        = out_vld && last_byte;

endmodule
